// File: rtl/mdu_core_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
// The pipeline side drives the request, the unit drives status and HI/LO.
interface mdu_core_if;
  logic        i_Start;
  logic [3:0]  i_Op;
  logic [31:0] i_A;
  logic [31:0] i_B;
  logic        i_Flush;
  logic        o_Busy;
  logic        o_Done;
  logic [31:0] o_HI;
  logic [31:0] o_LO;

  modport master (
    output i_Start, i_Op, i_A, i_B, i_Flush,
    input  o_Busy, o_Done, o_HI, o_LO
  );

  modport slave (
    input  i_Start, i_Op, i_A, i_B, i_Flush,
    output o_Busy, o_Done, o_HI, o_LO
  );
endinterface

// File: rtl/mdu_core.sv
// MIPS-style HI/LO multiply/divide unit: the result is computed at issue,
// held for a fixed latency, then committed to HI/LO when the counter expires.
module mdu_core #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_core_if.slave  bus
);
  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6
  } op_e;

  logic [CW-1:0] r_cnt;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [63:0]   r_res;
  logic          r_wr;

  logic          w_sgn;
  logic          w_long;
  logic          w_div;
  logic          w_wr;
  logic          w_issue;
  logic [CW-1:0] w_lat;
  logic [63:0]   w_mul_a;
  logic [63:0]   w_mul_b;
  logic [63:0]   w_res;
  logic [31:0]   w_mag_a;
  logic [31:0]   w_mag_b;
  logic [31:0]   w_div_b;
  logic [31:0]   w_q;
  logic [31:0]   w_r;

  always_comb begin
    w_sgn  = 1'b0;
    w_long = 1'b0;
    w_div  = 1'b0;
    w_lat  = '0;
    case (bus.i_Op)
      OP_MULT:  begin w_sgn = 1'b1; w_long = 1'b1; w_lat = CW'(MULT_LAT); end
      OP_MULTU: begin w_long = 1'b1; w_lat = CW'(MULT_LAT); end
      OP_DIV:   begin w_sgn = 1'b1; w_long = 1'b1; w_div = 1'b1; w_lat = CW'(DIV_LAT); end
      OP_DIVU:  begin w_long = 1'b1; w_div = 1'b1; w_lat = CW'(DIV_LAT); end
      default:  ;
    endcase

    w_mul_a = {{32{w_sgn & bus.i_A[31]}}, bus.i_A};
    w_mul_b = {{32{w_sgn & bus.i_B[31]}}, bus.i_B};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // without relying on signed-overflow behaviour of the divider.
    w_mag_a = (w_sgn && bus.i_A[31]) ? -bus.i_A : bus.i_A;
    w_mag_b = (w_sgn && bus.i_B[31]) ? -bus.i_B : bus.i_B;
    w_div_b = (bus.i_B == '0) ? 32'd1 : w_mag_b;
    w_q     = w_mag_a / w_div_b;
    w_r     = w_mag_a % w_div_b;
    if (w_sgn && (bus.i_A[31] ^ bus.i_B[31])) w_q = -w_q;
    if (w_sgn && bus.i_A[31])                 w_r = -w_r;

    if (w_div) begin
      w_res = {w_r, w_q};
      w_wr  = (bus.i_B != '0);
    end else begin
      w_res = w_mul_a * w_mul_b;
      w_wr  = 1'b1;
    end
  end

  assign w_issue = bus.i_Start & ~bus.i_Flush & (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_res <= '0;
      r_wr  <= 1'b0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1) && r_wr) begin
        r_hi <= r_res[63:32];
        r_lo <= r_res[31:0];
      end
    end else if (w_issue) begin
      if (w_long) begin
        r_res <= w_res;
        r_wr  <= w_wr;
        r_cnt <= w_lat;
      end else if (bus.i_Op == OP_MTHI) begin
        r_hi <= bus.i_A;
      end else if (bus.i_Op == OP_MTLO) begin
        r_lo <= bus.i_A;
      end
    end
  end

  assign bus.o_Busy = (r_cnt != '0) | (bus.i_Start & ~bus.i_Flush & w_long);
  assign bus.o_Done = (r_cnt == CW'(1));
  assign bus.o_HI   = r_hi;
  assign bus.o_LO   = r_lo;
endmodule

// File: tb/tb_mdu_core.sv
// Directed and randomized checks of mdu_core against an arithmetic reference model.
module tb_mdu_core;
  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  logic clk;
  logic reset;
  mdu_core_if bus ();

  mdu_core #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  logic        m_pend_ok;
  int          m_cnt;

  function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int    ia;
    int    ib;
    longint p;
    logic [63:0] ua;
    logic [63:0] ub;
    if (sgn) begin
      ia = a;
      ib = b;
      p  = longint'(ia) * longint'(ib);
      return p;
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Returns {remainder, quotient}
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int ia;
    int ib;
    int q;
    int r;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    ia = a;
    ib = b;
    q  = ia / ib;
    r  = ia % ib;
    return {r, q};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check outputs, advance model, wait for next negedge.
  task automatic step(input logic st, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic fl, input logic rs);
    logic exp_busy;
    bus.i_Start = st;
    bus.i_Op    = op;
    bus.i_A     = a;
    bus.i_B     = b;
    bus.i_Flush = fl;
    reset       = rs;
    #1;
    exp_busy = (m_cnt != 0) || (st && !fl && op >= 4'd1 && op <= 4'd4);
    chk("busy", {31'd0, bus.o_Busy}, {31'd0, exp_busy});
    chk("done", {31'd0, bus.o_Done}, {31'd0, (m_cnt == 1)});
    chk("hi", bus.o_HI, m_hi);
    chk("lo", bus.o_LO, m_lo);
    if (rs) begin
      m_hi = '0; m_lo = '0; m_cnt = 0; m_pend = '0; m_pend_ok = 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt--;
      if (m_cnt == 0 && m_pend_ok) begin
        m_hi = m_pend[63:32];
        m_lo = m_pend[31:0];
      end
    end else if (st && !fl) begin
      case (op)
        4'd1: begin m_pend = ref_mul(1'b1, a, b); m_pend_ok = 1'b1; m_cnt = MULT_LAT; end
        4'd2: begin m_pend = ref_mul(1'b0, a, b); m_pend_ok = 1'b1; m_cnt = MULT_LAT; end
        4'd3: begin m_pend_ok = (b != 0); if (b != 0) m_pend = ref_div(1'b1, a, b); m_cnt = DIV_LAT; end
        4'd4: begin m_pend_ok = (b != 0); if (b != 0) m_pend = ref_div(1'b0, a, b); m_cnt = DIV_LAT; end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, $urandom, $urandom, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0]  op;
    logic        st;
    logic        fl;
    logic        rs;
    checks = 0;
    errors = 0;
    m_hi = '0; m_lo = '0; m_pend = '0; m_pend_ok = 1'b0; m_cnt = 0;
    bus.i_Start = 1'b0; bus.i_Op = '0; bus.i_A = '0; bus.i_B = '0; bus.i_Flush = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    step(1'b0, 4'd0, '0, '0, 1'b0, 1'b1);
    step(1'b0, 4'd0, '0, '0, 1'b0, 1'b1);

    // Signed multiply of negative by positive
    step(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    idle(MULT_LAT);
    chk("mult_hi", bus.o_HI, 32'hFFFF_FFFF);
    chk("mult_lo", bus.o_LO, 32'hFFFF_FFFA);

    // Unsigned multiply of all-ones
    step(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(MULT_LAT);
    chk("multu_hi", bus.o_HI, 32'hFFFF_FFFE);
    chk("multu_lo", bus.o_LO, 32'h0000_0001);

    // Signed and unsigned divide of -7 by 2
    step(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(DIV_LAT);
    chk("div_lo", bus.o_LO, 32'hFFFF_FFFD);
    chk("div_hi", bus.o_HI, 32'hFFFF_FFFF);
    step(1'b1, 4'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(DIV_LAT);
    chk("divu_lo", bus.o_LO, 32'h7FFF_FFFC);
    chk("divu_hi", bus.o_HI, 32'h0000_0001);

    // Overflowing signed divide
    step(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(DIV_LAT);
    chk("divovf_lo", bus.o_LO, 32'h8000_0000);
    chk("divovf_hi", bus.o_HI, 32'h0000_0000);

    // MTHI then divide by zero leaves HI/LO untouched
    step(1'b0, 4'd0, '0, '0, 1'b0, 1'b1);
    step(1'b1, 4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    step(1'b1, 4'd3, 32'd5, 32'd0, 1'b0, 1'b0);
    idle(DIV_LAT);
    chk("div0_hi", bus.o_HI, 32'h1234_5678);
    chk("div0_lo", bus.o_LO, 32'h0000_0000);

    // Flushed issue, then a second request while busy is ignored
    step(1'b1, 4'd1, 32'd3, 32'd3, 1'b1, 1'b0);
    chk("flush_lo", bus.o_LO, 32'h0000_0000);
    step(1'b1, 4'd1, 32'd7, 32'd9, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 4'd1, 32'd100, 32'd100, 1'b0, 1'b0);
    idle(2);
    chk("ignored_lo", bus.o_LO, 32'd63);
    chk("ignored_hi", bus.o_HI, 32'd0);

    // Reset in the middle of a divide aborts it
    step(1'b1, 4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    idle(DIV_LAT - 4);
    step(1'b0, 4'd0, '0, '0, 1'b0, 1'b1);
    chk("abort_hi", bus.o_HI, 32'd0);
    chk("abort_lo", bus.o_LO, 32'd0);
    idle(DIV_LAT);

    // Randomized mix of operations, flushes, stray requests and resets
    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(1, 6));
      st = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 99) == 0);
      step(st, op, rnd_val(), rnd_val(), fl, rs);
    end
    idle(DIV_LAT + 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
